// File: rtl/case_stream_xform.sv
// rtl/case_stream_xform.sv - multi-channel escape-commanded case converter with output FIFO
module case_stream_xform #(
    parameter int          NUM_CH     = 2,
    parameter int          CH_W       = 1,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  ESC_CHAR   = 8'h1B,
    parameter logic [1:0]  RESET_MODE = 2'b00
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    input  logic [CH_W-1:0]       in_chan,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic [CH_W-1:0]       out_chan,
    output logic [2*NUM_CH-1:0]   mode_o,
    output logic                  bad_cmd
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] M_N = 2'b00;
    localparam logic [1:0] M_L = 2'b01;
    localparam logic [1:0] M_U = 2'b10;
    localparam logic [1:0] M_C = 2'b11;

    localparam logic [7:0] CMD_N = 8'h4E;
    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_U = 8'h55;
    localparam logic [7:0] CMD_C = 8'h43;

    // per-channel parser state
    logic [1:0]        mode_q [NUM_CH];
    logic [NUM_CH-1:0] esc_q;

    // output FIFO storage and bookkeeping
    logic [7:0]        mem_data [FIFO_DEPTH];
    logic [CH_W-1:0]   mem_chan [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    // decoded input byte
    logic [NUM_CH-1:0] hit;
    logic              chan_ok;
    logic [1:0]        cur_mode;
    logic              cur_esc;
    logic              accept;
    logic              push;
    logic              pop;
    logic [7:0]        push_data;
    logic              set_esc;
    logic              clr_esc;
    logic              mode_wr;
    logic [1:0]        new_mode;
    logic              bad_now;

    // Letters only; every other byte passes through untouched in all modes.
    function automatic logic [7:0] xform(input logic [7:0] b, input logic [1:0] m);
        logic       is_up;
        logic       is_lo;
        logic [7:0] r;
        is_up = (b >= 8'h41) && (b <= 8'h5A);
        is_lo = (b >= 8'h61) && (b <= 8'h7A);
        r     = b;
        case (m)
            M_L: if (is_up) r = b + 8'h20;
            M_U: if (is_lo) r = b - 8'h20;
            M_C: begin
                if (is_up)      r = b + 8'h20;
                else if (is_lo) r = b - 8'h20;
            end
            default: r = b;
        endcase
        return r;
    endfunction

    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign out_data  = mem_data[rd_ptr];
    assign out_chan  = mem_chan[rd_ptr];
    assign pop       = out_valid && out_ready;

    // Decode the channel tag and fetch that channel's parser state.
    always_comb begin
        hit      = '0;
        cur_mode = M_N;
        cur_esc  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            hit[c] = (in_chan == CH_W'(c));
            if (hit[c]) begin
                cur_mode = mode_q[c];
                cur_esc  = esc_q[c];
            end
        end
        chan_ok = |hit;
        // Tags beyond NUM_CH are still handshaken so the source never stalls on them.
        accept  = in_valid && in_ready && chan_ok;
    end

    // Escape-sequence parser: decide push / mode change / error for the accepted byte.
    always_comb begin
        push      = 1'b0;
        push_data = in_data;
        set_esc   = 1'b0;
        clr_esc   = 1'b0;
        mode_wr   = 1'b0;
        new_mode  = cur_mode;
        bad_now   = 1'b0;
        if (accept) begin
            if (!cur_esc) begin
                if (in_data == ESC_CHAR) begin
                    set_esc = 1'b1;
                end else begin
                    push      = 1'b1;
                    push_data = xform(in_data, cur_mode);
                end
            end else begin
                clr_esc = 1'b1;
                if (in_data == CMD_N) begin
                    mode_wr  = 1'b1;
                    new_mode = M_N;
                end else if (in_data == CMD_L) begin
                    mode_wr  = 1'b1;
                    new_mode = M_L;
                end else if (in_data == CMD_U) begin
                    mode_wr  = 1'b1;
                    new_mode = M_U;
                end else if (in_data == CMD_C) begin
                    mode_wr  = 1'b1;
                    new_mode = M_C;
                end else if (in_data == ESC_CHAR) begin
                    // Doubled escape emits one literal escape, never case-converted.
                    push      = 1'b1;
                    push_data = ESC_CHAR;
                end else begin
                    bad_now = 1'b1;
                end
            end
        end
    end

    // Per-channel mode and escape-pending registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mode_q[c] <= RESET_MODE;
            end
            esc_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (hit[c] && accept) begin
                    if (set_esc) esc_q[c]  <= 1'b1;
                    if (clr_esc) esc_q[c]  <= 1'b0;
                    if (mode_wr) mode_q[c] <= new_mode;
                end
            end
        end
    end

    // Illegal-command flag, high for the one cycle after the offending byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bad_cmd <= 1'b0;
        end else begin
            bad_cmd <= bad_now;
        end
    end

    // Output FIFO: write at wr_ptr, read at rd_ptr, occupancy in count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_chan[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= push_data;
                mem_chan[wr_ptr] <= in_chan;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Flatten per-channel modes onto the status bus.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_mode
        assign mode_o[2*g+1:2*g] = mode_q[g];
    end

endmodule

// File: tb/tb_case_stream_xform.sv
// tb/tb_case_stream_xform.sv - randomized model-checked bench for case_stream_xform
module tb_case_stream_xform;

    localparam int         NUM_CH = 2;
    localparam int         CH_W   = 1;
    localparam int         DEPTH  = 4;
    localparam logic [7:0] ESC    = 8'h1B;

    logic              clock;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic [CH_W-1:0]   in_chan;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic [CH_W-1:0]   out_chan;
    logic [2*NUM_CH-1:0] mode_o;
    logic              bad_cmd;

    int checks   = 0;
    int failures = 0;

    case_stream_xform #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .FIFO_DEPTH(DEPTH),
        .ESC_CHAR(ESC), .RESET_MODE(2'b00)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chan(in_chan),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
        .mode_o(mode_o), .bad_cmd(bad_cmd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [8:0] mq[$];
    logic [1:0] m_mode [NUM_CH];
    bit         m_esc  [NUM_CH];
    bit         m_bad;
    bit         m_vld;
    bit         m_rdy;

    function automatic logic [7:0] ref_xform(input logic [7:0] b, input logic [1:0] m);
        bit up, lo;
        up = (b >= "A") && (b <= "Z");
        lo = (b >= "a") && (b <= "z");
        if (!(up || lo)) return b;
        case (m)
            2'd1:    return b | 8'h20;
            2'd2:    return b & 8'hDF;
            2'd3:    return b ^ 8'h20;
            default: return b;
        endcase
    endfunction

    task automatic model_byte(input logic [CH_W-1:0] ch, input logic [7:0] b);
        int c;
        c = int'(ch);
        if (!m_esc[c]) begin
            if (b == ESC) m_esc[c] = 1;
            else mq.push_back({ch, ref_xform(b, m_mode[c])});
        end else begin
            m_esc[c] = 0;
            if      (b == "N") m_mode[c] = 2'd0;
            else if (b == "L") m_mode[c] = 2'd1;
            else if (b == "U") m_mode[c] = 2'd2;
            else if (b == "C") m_mode[c] = 2'd3;
            else if (b == ESC) mq.push_back({ch, ESC});
            else m_bad = 1;
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            for (int c = 0; c < NUM_CH; c++) begin
                m_mode[c] = 2'd0;
                m_esc[c]  = 0;
            end
            m_bad = 0;
        end else begin
            m_vld = (mq.size() != 0);
            m_rdy = (mq.size() != DEPTH);
            m_bad = 0;
            if (m_vld && out_ready) void'(mq.pop_front());
            if (in_valid && m_rdy) model_byte(in_chan, in_data);
        end
    end

    // ---------------- per-cycle compare and output log ----------------
    logic [8:0] obs[$];

    always @(negedge clock) begin
        if (!reset) begin
            check("in_ready", in_ready, mq.size() != DEPTH);
            check("out_valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) check("out_head", {out_chan, out_data}, mq[0]);
            check("mode_o", mode_o, {m_mode[1], m_mode[0]});
            check("bad_cmd", bad_cmd, m_bad);
            if (out_valid && out_ready) obs.push_back({out_chan, out_data});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [CH_W-1:0] ch, input logic [7:0] b);
        bit rdy;
        int budget;
        budget   = 200;
        in_valid = 1'b1;
        in_chan  = ch;
        in_data  = b;
        do begin
            @(negedge clock);
            rdy = in_ready;
            @(posedge clock);
            budget--;
        end while (!rdy && budget > 0);
        #1;
        in_valid = 1'b0;
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=stalled required=accepted");
        end
    endtask

    task automatic chk_obs(input string nm, input logic [8:0] exp);
        checks++;
        if (obs.size() == 0) begin
            failures++;
            $display("FAIL %s actual=none required=%0h", nm, exp);
        end else begin
            logic [8:0] got;
            got = obs.pop_front();
            if (got !== exp) begin
                failures++;
                $display("FAIL %s actual=%0h required=%0h", nm, got, exp);
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_chan   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_chan", out_chan, 0);
        check("rst_mode_o", mode_o, 4'b0000);
        check("rst_bad_cmd", bad_cmd, 0);
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);

        // mode N pass-through, one-cycle latency
        obs.delete();
        send(0, 8'h61);
        check("t1_lat_valid", out_valid, 1);
        check("t1_lat_data", out_data, 8'h61);
        send(0, 8'h41);
        send(0, 8'h31);
        idle(3);
        chk_obs("t1_b0", 9'h061);
        chk_obs("t1_b1", 9'h041);
        chk_obs("t1_b2", 9'h031);

        // upper mode on ch0
        send(0, 8'h1B);
        send(0, 8'h55);
        check("t2_mode", mode_o[1:0], 2'b10);
        send(0, 8'h61);
        send(0, 8'h7A);
        send(0, 8'h5B);
        idle(3);
        chk_obs("t2_b0", 9'h041);
        chk_obs("t2_b1", 9'h05A);
        chk_obs("t2_b2", 9'h05B);

        // interleaved escapes
        send(0, 8'h1B);
        send(1, 8'h1B);
        send(1, 8'h4C);
        send(0, 8'h43);
        send(0, 8'h61);
        send(1, 8'h41);
        idle(3);
        check("t3_modes", mode_o, 4'b0111);
        chk_obs("t3_b0", 9'h041);
        chk_obs("t3_b1", 9'h161);

        // literal escape and illegal command
        send(0, 8'h1B);
        send(0, 8'h1B);
        idle(3);
        chk_obs("t4_lit", 9'h01B);
        send(0, 8'h1B);
        send(0, 8'h58);
        check("t4_bad_hi", bad_cmd, 1);
        idle(1);
        check("t4_bad_lo", bad_cmd, 0);
        check("t4_mode", mode_o[1:0], 2'b11);
        idle(3);
        check("t4_no_out", obs.size(), 0);

        // back-pressure: fill FIFO, hold head, then drain
        out_ready = 1'b0;
        send(1, 8'h41);
        send(1, 8'h42);
        send(1, 8'h33);
        send(1, 8'h5A);
        in_valid = 1'b1;
        in_chan  = 1;
        in_data  = 8'h44;
        repeat (3) begin
            @(negedge clock);
            check("t5_full", in_ready, 0);
            check("t5_head", out_data, 8'h61);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        send(1, 8'h44);
        idle(6);
        chk_obs("t5_b0", 9'h161);
        chk_obs("t5_b1", 9'h162);
        chk_obs("t5_b2", 9'h133);
        chk_obs("t5_b3", 9'h17A);
        chk_obs("t5_b4", 9'h164);

        // reset mid-stream with queued data and a pending escape
        out_ready = 1'b0;
        send(0, 8'h1B);
        send(1, 8'h31);
        send(1, 8'h32);
        send(1, 8'h33);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("t6_valid", out_valid, 0);
        check("t6_modes", mode_o, 4'b0000);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        check("t6_in_ready", in_ready, 1);
        obs.delete();
        send(0, 8'h4C);
        idle(3);
        chk_obs("t6_b0", 9'h04C);
        check("t6_mode_after", mode_o, 4'b0000);

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            int r;
            in_valid = ($urandom_range(0, 3) != 0);
            in_chan  = CH_W'($urandom_range(0, NUM_CH - 1));
            r = $urandom_range(0, 9);
            if (r < 2) begin
                in_data = ESC;
            end else if (r == 2) begin
                case ($urandom_range(0, 3))
                    0:       in_data = 8'h4E;
                    1:       in_data = 8'h4C;
                    2:       in_data = 8'h55;
                    default: in_data = 8'h43;
                endcase
            end else if (r == 3) begin
                in_data = 8'($urandom_range(0, 255));
            end else begin
                in_data = 8'($urandom_range(8'h20, 8'h7E));
            end
            if ((i / 100) % 4 == 3) out_ready = ($urandom_range(0, 7) == 0);
            else                    out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clock);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(10);
        check("drain_empty", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/case_stream_xform.md
Name: case_stream_xform

Overview:
Parametrised, multi-channel successor to the single-stream escape-commanded case converter.
- Accepts interleaved ASCII bytes tagged with a channel number.
- Keeps an independent escape-sequence parser and case mode for each channel.
- Transforms only alphabetic bytes.
- Delivers results through a valid/ready output FIFO, so downstream back-pressure is tolerated.
- Sits between the character source and the output register stage of the text-path datapath.

Parameters:
NUM_CH, 2, number of independent channels (1..2**CH_W)
CH_W, 1, width of channel tag
FIFO_DEPTH, 4, output FIFO entries; power of two, >=2
ESC_CHAR, 8'h1B, escape byte that introduces a command
RESET_MODE, 2'b00, mode loaded into every channel at reset (00=N pass, 01=L lower, 10=U upper, 11=C change case)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input byte valid
in_ready  output  1  input byte accepted when in_valid && in_ready
in_data  input  8  ASCII byte
in_chan  input  CH_W  channel tag of in_data; values >= NUM_CH are ignored (accepted and dropped)
out_valid  output  1  FIFO head valid
out_ready  input  1  downstream accepts head
out_data  output  8  transformed byte
out_chan  output  CH_W  channel tag of out_data
mode_o  output  2*NUM_CH  current mode per channel; channel c occupies bits [2c+1:2c]
bad_cmd  output  1  one-cycle pulse: illegal command byte after ESC

Behaviour:
- Clock and reset: one clock, one domain. Reset is asynchronous and active-high, named clock and reset as in the rest of the codebase.
- Reset (asynchronous, immediate):
  - FIFO empty; out_valid=0, out_data=0, out_chan=0.
  - All modes = RESET_MODE; all esc_pend=0; bad_cmd=0.
  - in_ready follows the empty FIFO, so it is 1 once reset deasserts.
  - Bytes in flight or queued are discarded.
- in_ready = (fifo_count != FIFO_DEPTH). There is no full-bypass: when the FIFO is full, in_ready=0 even if out_ready=1.
- Accepted byte b on channel c, per-channel parser:
  - esc_pend[c]=0, b==ESC_CHAR: set esc_pend[c]; nothing pushed.
  - esc_pend[c]=0, other b: push {c, xform(b, mode[c])}.
  - esc_pend[c]=1: clear esc_pend[c], then:
    - b in {8'h4E N, 8'h4C L, 8'h55 U, 8'h43 C}: mode[c] <= 00/01/10/11 respectively; nothing pushed.
    - b==ESC_CHAR: push {c, ESC_CHAR} untransformed (literal escape).
    - any other b: byte dropped, mode unchanged, bad_cmd=1 for exactly the following cycle.
- A mode change applies from the next byte of that channel. Other channels are unaffected; each channel's esc_pend survives interleaving with other channels.
- xform:
  - upper = 8'h41..8'h5A; lower = 8'h61..8'h7A.
  - Non-letters pass unchanged in all modes.
  - L: upper+8'h20. U: lower-8'h20. C: upper+8'h20, lower-8'h20. N: identity.
- Output FIFO:
  - Registered. A byte pushed at edge k is visible with out_valid=1 after edge k, so latency is 1 cycle when the FIFO is empty.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- out_data and out_chan are held stable while out_valid && !out_ready.
- mode_o and bad_cmd are registered outputs. mode_o reflects the update after the accepting edge.

Test Plan:
- Reset, then ch0 sends 8'h61,8'h41,8'h31 in mode N -> out 8'h61,8'h41,8'h31, out_chan=0, 1-cycle latency each.
- ch0 sends 1B,55,61,7A,5B -> mode_o[1:0]=10; out 41,5A,5B (8'h5B non-letter unchanged).
- Interleave ch0:1B, ch1:1B, ch1:4C, ch0:43, ch0:61, ch1:41 -> ch0 mode 11, ch1 mode 01; out {0,41},{1,61}.
- ch0 sends 1B,1B then 1B,58 -> first pair outputs one 8'h1B; second pair gives bad_cmd pulse, no output, mode unchanged.
- Hold out_ready=0 and send 5 bytes with FIFO_DEPTH=4 -> in_ready=0 after 4 accepts, head stable; raise out_ready -> 4 bytes drain in order, 5th then accepted.
- Assert reset mid-stream with FIFO holding 3 entries and ch0 esc_pend=1 -> out_valid=0 immediately, modes=RESET_MODE; next 8'h4C on ch0 outputs 8'h4C (not treated as a command).
